// File: rtl/sobel_stream_if.sv
// Stream-side handshake bundle for sobel_stream: upstream show-ahead FIFO pop side,
// downstream FIFO push side, threshold input and end-of-frame pulse.
interface sobel_stream_if #(
  parameter int PIX_W = 8
);
  logic             in_rd_en;
  logic             in_empty;
  logic [PIX_W-1:0] in_dout;
  logic             out_wr_en;
  logic             out_full;
  logic [PIX_W-1:0] out_din;
  logic [PIX_W-1:0] threshold;
  logic             done;

  modport master (
    input  in_rd_en, out_wr_en, out_din, done,
    output in_empty, in_dout, out_full, threshold
  );

  modport slave (
    output in_rd_en, out_wr_en, out_din, done,
    input  in_empty, in_dout, out_full, threshold
  );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector between two FIFOs, one output pixel per input pixel,
// with zeroed image borders and either clamped-magnitude or thresholded output.
module sobel_stream #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int PIX_W      = 8,
  parameter int MODE       = 0
) (
  input  logic          clock,
  input  logic          reset,
  sobel_stream_if.slave bus
);
  localparam int W     = IMG_WIDTH;
  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int TAPS  = 2 * W + 2;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
  localparam int COL_W = $clog2(IMG_WIDTH + 1);
  localparam int GW    = PIX_W + 3;

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [PIX_W-1:0] thr_q, thr_d;
  logic [PIX_W-1:0] sr_q [TAPS];
  logic             shift;

  // The FIFO head acts as tap 0, so the window already includes the pixel being popped.
  logic [PIX_W-1:0] tap [TAPS+1];
  always_comb begin
    tap[0] = bus.in_dout;
    for (int i = 1; i <= TAPS; i++) tap[i] = sr_q[i-1];
  end

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return signed'({3'b000, p});
  endfunction

  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        ax, ay;
  logic [GW:0]          mag;
  logic [PIX_W-1:0]     pix_val;
  logic                 border;

  always_comb begin
    gx = (ext(tap[2*W]) + (ext(tap[W]) <<< 1) + ext(tap[0]))
       - (ext(tap[2*W+2]) + (ext(tap[W+2]) <<< 1) + ext(tap[2]));
    gy = (ext(tap[2]) + (ext(tap[1]) <<< 1) + ext(tap[0]))
       - (ext(tap[2*W+2]) + (ext(tap[2*W+1]) <<< 1) + ext(tap[2*W]));
    ax = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = {1'b0, ax} + {1'b0, ay};
    if (MODE == 0)
      pix_val = (mag > (GW+1)'({PIX_W{1'b1}})) ? '1 : mag[PIX_W-1:0];
    else
      pix_val = (mag >= (GW+1)'(thr_q)) ? '1 : '0;
    border = (row_q == '0) || (row_q == ROW_W'(IMG_HEIGHT-1)) ||
             (col_q == '0) || (col_q == COL_W'(IMG_WIDTH-1));
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    row_d         = row_q;
    col_d         = col_q;
    thr_d         = thr_q;
    shift         = 1'b0;
    bus.in_rd_en  = 1'b0;
    bus.out_wr_en = 1'b0;
    bus.out_din   = '0;
    bus.done      = 1'b0;
    unique case (state_q)
      S_FILL: if (!bus.in_empty) begin
        bus.in_rd_en = 1'b1;
        shift        = 1'b1;
        if (cnt_q == CNT_W'(W)) thr_d = bus.threshold;
        if (cnt_q == '0) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(NPIX - W - 2);
          row_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RUN: if (!bus.in_empty && !bus.out_full) begin
        bus.in_rd_en  = 1'b1;
        bus.out_wr_en = 1'b1;
        bus.out_din   = border ? '0 : pix_val;
        shift         = 1'b1;
        if (col_q == COL_W'(IMG_WIDTH-1)) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = S_FLUSH;
          cnt_d   = CNT_W'(W);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FLUSH: if (!bus.out_full) begin
        bus.out_wr_en = 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_FILL;
        cnt_d    = CNT_W'(W);
      end
    endcase
    if (reset) begin
      shift         = 1'b0;
      bus.in_rd_en  = 1'b0;
      bus.out_wr_en = 1'b0;
      bus.out_din   = '0;
      bus.done      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FILL;
      cnt_q   <= CNT_W'(W);
      row_q   <= '0;
      col_q   <= '0;
      thr_q   <= '0;
      for (int i = 0; i < TAPS; i++) sr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      thr_q   <= thr_d;
      if (shift) begin
        sr_q[0] <= bus.in_dout;
        for (int i = 1; i < TAPS; i++) sr_q[i] <= sr_q[i-1];
      end
    end
  end
endmodule
